// File: rtl/ghost_catch_monitor.sv
// Pacman/ghost collision monitor: confirms contact over successive movement ticks,
// then sequences catch -> freeze -> respawn handshake -> play, or game over.
module ghost_catch_monitor #(
    parameter int HIT_DIST     = 16,
    parameter int CONFIRM      = 2,
    parameter int FREEZE_TICKS = 60,
    parameter int LIVES_INIT   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [9:0]  pac_x,
    input  logic [8:0]  pac_y,
    input  logic [39:0] ghost_x,
    input  logic [35:0] ghost_y,
    input  logic [3:0]  ghost_en,
    input  logic        respawn_ack,
    input  logic        restart,
    output logic        freeze,
    output logic        respawn_req,
    output logic        hit_pulse,
    output logic [1:0]  hit_ghost,
    output logic [1:0]  lives,
    output logic        game_over
);

    typedef enum logic [1:0] {
        ST_PLAY    = 2'd0,
        ST_FREEZE  = 2'd1,
        ST_RESPAWN = 2'd2,
        ST_OVER    = 2'd3
    } state_t;

    localparam logic [9:0] HIT_X     = 10'(HIT_DIST);
    localparam logic [8:0] HIT_Y     = 9'(HIT_DIST);
    localparam logic [3:0] CONF_LAST = 4'(CONFIRM - 1);
    localparam logic [7:0] FRZ_LAST  = 8'(FREEZE_TICKS - 1);
    localparam logic [1:0] LIVES_RST = 2'(LIVES_INIT);

    // Distances are taken at full width so positions never wrap around the screen edge.
    function automatic logic [9:0] absdiff10(input logic [9:0] a, input logic [9:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [8:0] absdiff9(input logic [8:0] a, input logic [8:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    state_t      state_r, state_s;
    logic [3:0]  confirm_r, confirm_s;
    logic [7:0]  fcnt_r, fcnt_s;
    logic [1:0]  lives_r, lives_s;
    logic [1:0]  hit_ghost_r, hit_ghost_s;
    logic        hit_pulse_r, hit_pulse_s;
    logic        freeze_r, respawn_req_r, game_over_r;
    logic [3:0]  contact_s;
    logic [1:0]  hit_idx_s;
    logic        any_contact_s;

    // Per-ghost contact detection and lowest-index selection.
    always_comb begin
        contact_s = 4'b0000;
        hit_idx_s = 2'd0;
        for (int i = 0; i < 4; i++) begin
            contact_s[i] = ghost_en[i]
                         && (absdiff10(ghost_x[10*i +: 10], pac_x) < HIT_X)
                         && (absdiff9(ghost_y[9*i +: 9], pac_y) < HIT_Y);
        end
        for (int i = 3; i >= 0; i--) begin
            if (contact_s[i]) begin
                hit_idx_s = 2'(i);
            end else begin
                hit_idx_s = hit_idx_s;
            end
        end
        any_contact_s = |contact_s;
    end

    // Next-state and next-datapath logic; restart overrides every state.
    always_comb begin
        state_s     = state_r;
        confirm_s   = confirm_r;
        fcnt_s      = fcnt_r;
        lives_s     = lives_r;
        hit_ghost_s = hit_ghost_r;
        hit_pulse_s = 1'b0;
        if (restart) begin
            state_s   = ST_PLAY;
            confirm_s = 4'd0;
            fcnt_s    = 8'd0;
            lives_s   = LIVES_RST;
        end else begin
            case (state_r)
                ST_PLAY: begin
                    if (tick && any_contact_s) begin
                        if (confirm_r == CONF_LAST) begin
                            lives_s     = (lives_r != 2'd0) ? (lives_r - 2'd1) : 2'd0;
                            hit_ghost_s = hit_idx_s;
                            hit_pulse_s = 1'b1;
                            confirm_s   = 4'd0;
                            fcnt_s      = 8'd0;
                            state_s     = (lives_r <= 2'd1) ? ST_OVER : ST_FREEZE;
                        end else begin
                            confirm_s = confirm_r + 4'd1;
                        end
                    end else if (tick) begin
                        confirm_s = 4'd0;
                    end else begin
                        confirm_s = confirm_r;
                    end
                end
                ST_FREEZE: begin
                    if (tick) begin
                        if (fcnt_r == FRZ_LAST) begin
                            fcnt_s  = 8'd0;
                            state_s = ST_RESPAWN;
                        end else begin
                            fcnt_s = fcnt_r + 8'd1;
                        end
                    end else begin
                        fcnt_s = fcnt_r;
                    end
                end
                ST_RESPAWN: begin
                    if (respawn_ack) begin
                        confirm_s = 4'd0;
                        state_s   = ST_PLAY;
                    end else begin
                        state_s = ST_RESPAWN;
                    end
                end
                ST_OVER: begin
                    lives_s = 2'd0;
                end
                default: begin
                    state_s = ST_PLAY;
                end
            endcase
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_PLAY;
            confirm_r     <= 4'd0;
            fcnt_r        <= 8'd0;
            lives_r       <= LIVES_RST;
            hit_ghost_r   <= 2'd0;
            hit_pulse_r   <= 1'b0;
            freeze_r      <= 1'b0;
            respawn_req_r <= 1'b0;
            game_over_r   <= 1'b0;
        end else begin
            state_r       <= state_s;
            confirm_r     <= confirm_s;
            fcnt_r        <= fcnt_s;
            lives_r       <= lives_s;
            hit_ghost_r   <= hit_ghost_s;
            hit_pulse_r   <= hit_pulse_s;
            freeze_r      <= (state_s != ST_PLAY);
            respawn_req_r <= (state_s == ST_RESPAWN);
            game_over_r   <= (state_s == ST_OVER);
        end
    end

    assign freeze      = freeze_r;
    assign respawn_req = respawn_req_r;
    assign hit_pulse   = hit_pulse_r;
    assign hit_ghost   = hit_ghost_r;
    assign lives       = lives_r;
    assign game_over   = game_over_r;

endmodule

// File: tb/tb_ghost_catch_monitor.sv
// Self-checking bench for ghost_catch_monitor: contact-geometry vector table with a
// result scoreboard, plus hand sequences for freeze/respawn, game over, restart and reset.
module tb_ghost_catch_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [9:0]  pac_x;
    logic [8:0]  pac_y;
    logic [39:0] ghost_x;
    logic [35:0] ghost_y;
    logic [3:0]  ghost_en;
    logic        respawn_ack;
    logic        restart;
    logic        freeze, respawn_req, hit_pulse, game_over;
    logic [1:0]  hit_ghost, lives;

    int checks = 0;
    int errors = 0;
    int pcnt   = 0;

    ghost_catch_monitor dut (
        .clk(clk), .rst(rst), .tick(tick), .pac_x(pac_x), .pac_y(pac_y),
        .ghost_x(ghost_x), .ghost_y(ghost_y), .ghost_en(ghost_en),
        .respawn_ack(respawn_ack), .restart(restart), .freeze(freeze),
        .respawn_req(respawn_req), .hit_pulse(hit_pulse), .hit_ghost(hit_ghost),
        .lives(lives), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Count every cycle in which hit_pulse is high.
    always @(negedge clk) begin
        if (rst && hit_pulse) pcnt++;
    end

    typedef struct {
        logic [9:0]  px;
        logic [8:0]  py;
        logic [39:0] gx;
        logic [35:0] gy;
        logic [3:0]  en;
        int          nt;
        logic        exp_hit;
        logic [1:0]  exp_g;
    } vec_t;

    typedef struct {
        int         npulse;
        logic       last;
        logic [1:0] ghost;
        logic [1:0] lives;
        logic       frz;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_tick(output logic saw);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
        saw = hit_pulse;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    task automatic ticks(input int n);
        logic s;
        repeat (n) do_tick(s);
    endtask

    task automatic set_ghost(input int i, input logic [9:0] x, input logic [8:0] y);
        ghost_x[10*i +: 10] = x;
        ghost_y[9*i +: 9]   = y;
    endtask

    function automatic vec_t mk(input logic [9:0] px, input logic [8:0] py,
                                input logic [9:0] g0x, input logic [8:0] g0y,
                                input logic [9:0] g1x, input logic [8:0] g1y,
                                input logic [9:0] g2x, input logic [8:0] g2y,
                                input logic [9:0] g3x, input logic [8:0] g3y,
                                input logic [3:0] en, input int nt,
                                input logic eh, input logic [1:0] eg);
        vec_t v;
        v.px = px; v.py = py;
        v.gx = {g3x, g2x, g1x, g0x};
        v.gy = {g3y, g2y, g1y, g0y};
        v.en = en; v.nt = nt; v.exp_hit = eh; v.exp_g = eg;
        return v;
    endfunction

    initial begin
        logic s;
        int   base;
        exp_t e;
        rst = 1'b1; tick = 1'b0; restart = 1'b0; respawn_ack = 1'b0;
        pac_x = 10'd0; pac_y = 9'd0; ghost_x = 40'd0; ghost_y = 36'd0; ghost_en = 4'b0000;

        // far ghost positions used as fillers: (600,400)
        vecs[0] = mk(10'd100, 9'd100, 10'd600, 9'd400, 10'd600, 9'd400, 10'd110, 9'd105, 10'd600, 9'd400, 4'b0100, 2, 1'b1, 2'd2);
        vecs[1] = mk(10'd100, 9'd100, 10'd116, 9'd100, 10'd600, 9'd400, 10'd600, 9'd400, 10'd600, 9'd400, 4'b1111, 10, 1'b0, 2'd0);
        vecs[2] = mk(10'd100, 9'd100, 10'd100, 9'd84, 10'd600, 9'd400, 10'd600, 9'd400, 10'd600, 9'd400, 4'b0001, 6, 1'b0, 2'd0);
        vecs[3] = mk(10'd100, 9'd100, 10'd115, 9'd85, 10'd600, 9'd400, 10'd600, 9'd400, 10'd600, 9'd400, 4'b0001, 2, 1'b1, 2'd0);
        vecs[4] = mk(10'd100, 9'd100, 10'd105, 9'd100, 10'd600, 9'd400, 10'd600, 9'd400, 10'd95, 9'd95, 4'b1001, 2, 1'b1, 2'd0);
        vecs[5] = mk(10'd100, 9'd100, 10'd600, 9'd400, 10'd100, 9'd100, 10'd600, 9'd400, 10'd600, 9'd400, 4'b1101, 6, 1'b0, 2'd0);
        vecs[6] = mk(10'd100, 9'd100, 10'd600, 9'd400, 10'd600, 9'd400, 10'd600, 9'd400, 10'd85, 9'd115, 4'b1000, 2, 1'b1, 2'd3);
        vecs[7] = mk(10'd5, 9'd5, 10'd600, 9'd400, 10'd1020, 9'd505, 10'd600, 9'd400, 10'd600, 9'd400, 4'b0010, 6, 1'b0, 2'd0);
        vecs[8] = mk(10'd0, 9'd0, 10'd600, 9'd400, 10'd15, 9'd15, 10'd600, 9'd400, 10'd600, 9'd400, 4'b0010, 2, 1'b1, 2'd1);

        #1 rst = 1'b0;
        #2;
        chk("rst_async_freeze", 32'(freeze), 32'd0);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        chk("rst_lives", 32'(lives), 32'd3);
        chk("rst_hit_ghost", 32'(hit_ghost), 32'd0);
        chk("rst_flags", {29'd0, respawn_req, hit_pulse, game_over}, 32'd0);

        // Geometry table: each vector starts from a fresh game.
        for (int i = 0; i < 9; i++) begin
            pulse_restart();
            pac_x = vecs[i].px; pac_y = vecs[i].py;
            ghost_x = vecs[i].gx; ghost_y = vecs[i].gy; ghost_en = vecs[i].en;
            base = pcnt;
            e.npulse = vecs[i].exp_hit ? 1 : 0;
            e.last   = vecs[i].exp_hit;
            e.ghost  = vecs[i].exp_g;
            e.lives  = vecs[i].exp_hit ? 2'd2 : 2'd3;
            e.frz    = vecs[i].exp_hit;
            sb.push_back(e);
            s = 1'b0;
            for (int t = 0; t < vecs[i].nt; t++) do_tick(s);
            e = sb.pop_front();
            chk($sformatf("v%0d_pulses", i), 32'(pcnt - base), 32'(e.npulse));
            chk($sformatf("v%0d_last_tick_pulse", i), 32'(s), 32'(e.last));
            chk($sformatf("v%0d_lives", i), 32'(lives), 32'(e.lives));
            chk($sformatf("v%0d_freeze", i), 32'(freeze), 32'(e.frz));
            if (e.npulse != 0) chk($sformatf("v%0d_hit_ghost", i), 32'(hit_ghost), 32'(e.ghost));
        end

        // Interrupted contact restarts confirmation; ghost 0 sits on pac when placed.
        pulse_restart();
        pac_x = 10'd200; pac_y = 9'd200; ghost_en = 4'b0001;
        ghost_x = {4{10'd600}}; ghost_y = {4{9'd400}};
        base = pcnt;
        set_ghost(0, 10'd200, 9'd200); do_tick(s);
        set_ghost(0, 10'd600, 9'd400); do_tick(s);
        set_ghost(0, 10'd200, 9'd200); do_tick(s);
        chk("interrupted_no_catch", 32'(pcnt - base), 32'd0);
        do_tick(s);
        chk("second_consecutive_catch", 32'(s), 32'd1);
        chk("catch1_lives", 32'(lives), 32'd2);

        // Freeze: ack and contact ignored, 60th tick requests respawn.
        respawn_ack = 1'b1; cyc(1); respawn_ack = 1'b0;
        ticks(59);
        chk("freeze_59_no_req", {30'd0, respawn_req, freeze}, 32'd1);
        ticks(1);
        chk("freeze_60_req", {30'd0, respawn_req, freeze}, 32'd3);
        ticks(10);
        cyc(10);
        chk("respawn_held", {30'd0, respawn_req, freeze}, 32'd3);
        respawn_ack = 1'b1; cyc(1); respawn_ack = 1'b0;
        chk("ack_release", {30'd0, respawn_req, freeze}, 32'd0);
        base = pcnt;
        do_tick(s);
        chk("confirm_cleared_on_play", 32'(pcnt - base), 32'd0);
        do_tick(s);
        chk("catch2_lives", 32'(lives), 32'd1);

        // Third catch ends the game.
        ticks(60);
        respawn_ack = 1'b1; cyc(1); respawn_ack = 1'b0;
        ticks(2);
        chk("catch3_lives", 32'(lives), 32'd0);
        chk("game_over", {30'd0, game_over, freeze}, 32'd3);
        base = pcnt;
        respawn_ack = 1'b1;
        ticks(4);
        respawn_ack = 1'b0;
        chk("over_ignores", {29'd0, game_over, lives} + 32'(pcnt - base), 32'd4);
        pulse_restart();
        chk("restart_state", {28'd0, lives, game_over, freeze}, 32'd12);

        // Restart coincident with a catching tick discards the catch.
        base = pcnt;
        do_tick(s);
        restart = 1'b1; tick = 1'b1;
        cyc(1);
        restart = 1'b0; tick = 1'b0;
        cyc(1);
        chk("restart_vs_catch_pulse", 32'(pcnt - base), 32'd0);
        chk("restart_vs_catch_lives", {29'd0, lives, freeze}, 32'd6);

        // Asynchronous reset in the middle of freeze.
        ticks(2);
        chk("pre_reset_freeze", 32'(freeze), 32'd1);
        ticks(5);
        #2 rst = 1'b0;
        #1;
        chk("reset_immediate", {27'd0, freeze, respawn_req, hit_pulse, game_over, 1'b0}, 32'd0);
        chk("reset_lives", 32'(lives), 32'd3);
        set_ghost(0, 10'd600, 9'd400);
        cyc(2);
        rst = 1'b1;
        base = pcnt;
        cyc(4);
        chk("post_reset", {27'd0, lives, freeze, respawn_req, game_over} + 32'(pcnt - base), 32'd24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ghost_catch_monitor.md
GHOST_CATCH_MONITOR -- requirements
Module: ghost_catch_monitor

Interface
REQ-001 Parameter: HIT_DIST, 16, contact threshold in pixels per axis (strict less-than).
REQ-002 Parameter: CONFIRM, 2, consecutive contact ticks needed to register a catch (1..15).
REQ-003 Parameter: FREEZE_TICKS, 60, ticks the playfield stays frozen after a catch (1..255).
REQ-004 Parameter: LIVES_INIT, 3, lives loaded at reset and restart (1..3).
REQ-005 clk  in  1  single system clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset (rst=0 resets immediately, released synchronously to clk).
REQ-007 tick  in  1  one-cycle movement-tick pulse; sampling strobe for contact and freeze counting.
REQ-008 pac_x  in  10  Pacman X position; pac_y  in  9  Pacman Y position.
REQ-009 ghost_x  in  40  four 10-bit ghost X positions, ghost i at bits [10i+9:10i].
REQ-010 ghost_y  in  36  four 9-bit ghost Y positions, ghost i at bits [9i+8:9i].
REQ-011 ghost_en  in  4  per-ghost enable; disabled ghosts never make contact.
REQ-012 respawn_ack  in  1  level; positions reloaded by the movers.
REQ-013 restart  in  1  one-cycle pulse; new game.
REQ-014 freeze  out  1  level; movers halt while high.
REQ-015 respawn_req  out  1  level; request movers to reload start positions.
REQ-016 hit_pulse  out  1  one-cycle pulse per registered catch.
REQ-017 hit_ghost  out  2  index of catching ghost, held until next catch.
REQ-018 lives  out  2  remaining lives; game_over  out  1  level, no lives left.

Function
REQ-019 Contact for ghost i SHALL be ghost_en[i] & |ghost_x_i - pac_x| < HIT_DIST & |ghost_y_i - pac_y| < HIT_DIST, differences taken as unsigned absolute values at full input width (no wrap).
REQ-020 Any-contact SHALL be the OR of the four; the reported ghost SHALL be the lowest index in contact.
REQ-021 States SHALL be PLAY, FREEZE, RESPAWN, OVER.
REQ-022 PLAY: on tick with contact, confirm count increments; on tick without contact it clears; non-tick cycles hold it.
REQ-023 PLAY: on the tick where contact holds and confirm count = CONFIRM-1, the block SHALL, at that edge, decrement lives, latch hit_ghost, assert hit_pulse for exactly the following cycle, clear confirm count.
REQ-024 After a catch: if lives becomes 0 go to OVER, else go to FREEZE with freeze count 0.
REQ-025 FREEZE: freeze=1; count ticks; on the FREEZE_TICKS-th tick go to RESPAWN.
REQ-026 RESPAWN: freeze=1, respawn_req=1; on a cycle with respawn_ack=1 go to PLAY; freeze and respawn_req deassert the next cycle; confirm count is 0 on entry to PLAY.
REQ-027 Contact and ticks SHALL be ignored in FREEZE (except counting), RESPAWN and OVER.
REQ-028 OVER: freeze=1, game_over=1, lives=0; leaves only on restart.
REQ-029 restart SHALL have priority in every state: next state PLAY, lives=LIVES_INIT, counts cleared, hit_pulse=0, freeze=respawn_req=game_over=0; a catch coincident with restart is discarded.
REQ-030 respawn_ack outside RESPAWN SHALL be ignored.
REQ-031 lives SHALL never underflow below 0.

Reset
REQ-032 On rst=0: state PLAY, lives=LIVES_INIT, confirm and freeze counts 0, hit_ghost=0, freeze=respawn_req=hit_pulse=game_over=0.
REQ-033 rst asserted mid-FREEZE or mid-RESPAWN SHALL abort the sequence with no pending hit_pulse or request on release.

Verification
REQ-034 Pac (100,100), ghost 2 enabled at (110,105), two ticks -> hit_pulse one cycle after second tick, hit_ghost=2, lives 3->2, freeze=1.
REQ-035 Ghost at (116,100) vs pac (100,100) for 10 ticks -> no catch (dx=16 not < 16); ghost 0 and 3 both in contact -> hit_ghost=0.
REQ-036 Contact, no-contact, contact ticks -> no catch (count cleared); disabled ghost in contact -> no catch.
REQ-037 After catch, 60 ticks -> respawn_req=1; hold respawn_ack low 20 cycles -> state held; pulse ack -> freeze=0, respawn_req=0 next cycle.
REQ-038 Three catches -> lives=0, game_over=1, further contacts ignored; restart pulse -> lives=3, game_over=0, freeze=0; restart coincident with catch -> lives stays 3.
REQ-039 rst low during FREEZE -> all outputs at reset values immediately, lives=3 after release.
